// File: rtl/uart_rcv_cfg_if.sv
// Receiver-side signal bundle: serial input, consumer ack, received word and status.
interface uart_rcv_cfg_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 RX;
  logic                 clr_rdy;
  logic                 rdy;
  logic [DATA_BITS-1:0] rx_data;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    input  RX, clr_rdy,
    output rdy, rx_data, parity_err, frame_err, overrun
  );

  modport slave (
    output RX, clr_rdy,
    input  rdy, rx_data, parity_err, frame_err, overrun
  );
endinterface

// File: rtl/uart_rcv_cfg.sv
// Parametrised UART receiver: configurable divisor, width, parity and stop bits,
// with false-start rejection and parity/framing/overrun reporting.
module uart_rcv_cfg #(
  parameter int unsigned CLK_DIV   = 2604,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic           clk,
  input  logic           rst,
  uart_rcv_cfg_if.master bus
);

  localparam int unsigned BW = $clog2(CLK_DIV);
  localparam int unsigned CW = $clog2(DATA_BITS);

  localparam logic [BW-1:0] BAUD_FULL = BW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_s_q, rx_s_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [CW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_bit_q, par_bit_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic                 idle_low_q, idle_low_d;
  logic                 rdy_q, rdy_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  logic sample;
  logic par_x;
  logic ferr_now;

  always_comb begin
    state_d    = state_q;
    rx_meta_d  = bus.RX;
    rx_s_d     = rx_meta_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    stop_d     = stop_q;
    sh_d       = sh_q;
    par_bit_d  = par_bit_q;
    ferr_acc_d = ferr_acc_q;
    idle_low_d = idle_low_q;
    rdy_d      = rdy_q;
    data_d     = data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    ovr_d      = ovr_q;

    sample   = (state_q != S_IDLE) && (baud_q == '0);
    par_x    = (^sh_q) ^ par_bit_q;
    ferr_now = ferr_acc_q | ~rx_s_q;

    if (state_q != S_IDLE) begin
      baud_d = sample ? BAUD_FULL : baud_q - 1'b1;
    end

    if (bus.clr_rdy) begin
      rdy_d = 1'b0;
      ovr_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        // After a break the line must be seen high before a new start is accepted
        if (idle_low_q) begin
          if (rx_s_q) idle_low_d = 1'b0;
        end else if (!rx_s_q) begin
          baud_d  = BAUD_HALF;
          state_d = S_START;
        end
      end
      S_START: begin
        if (sample) begin
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            bit_d   = '0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (sample) begin
          sh_d  = {rx_s_q, sh_q[DATA_BITS-1:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
            stop_d     = 1'b0;
            ferr_acc_d = 1'b0;
            state_d    = (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (sample) begin
          par_bit_d = rx_s_q;
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (sample) begin
          if (stop_q == STOP_LAST) begin
            // Commit overrides a coincident clr_rdy; overrun uses the pre-clear rdy
            rdy_d      = 1'b1;
            ovr_d      = rdy_q | ovr_d;
            data_d     = sh_q;
            ferr_d     = ferr_now;
            perr_d     = (PARITY == 1) ? ~par_x : (PARITY == 2) ? par_x : 1'b0;
            idle_low_d = ~rx_s_q;
            state_d    = S_IDLE;
          end else begin
            stop_d     = stop_q + 1'b1;
            ferr_acc_d = ferr_now;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      baud_q     <= '0;
      bit_q      <= '0;
      stop_q     <= 1'b0;
      sh_q       <= '0;
      par_bit_q  <= 1'b0;
      ferr_acc_q <= 1'b0;
      idle_low_q <= 1'b0;
      rdy_q      <= 1'b0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_meta_q  <= rx_meta_d;
      rx_s_q     <= rx_s_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      stop_q     <= stop_d;
      sh_q       <= sh_d;
      par_bit_q  <= par_bit_d;
      ferr_acc_q <= ferr_acc_d;
      idle_low_q <= idle_low_d;
      rdy_q      <= rdy_d;
      data_q     <= data_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign bus.rdy        = rdy_q;
  assign bus.rx_data    = data_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;

endmodule
